// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the data memory (slave).
// Request is held until gnt; load data returns later with rvalid.
interface mem_stage_if #(
  parameter int XLEN = 64
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [7:0]      dmem_wstrb;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: runs load/store transactions on the dmem bus, emits write-back and redirect pulses.
// Optional MEM_MISALIGN_CHK_EN rejects misaligned accesses instead of rounding the lane offset down.
//
//   state | meaning
//   IDLE  | ready for EX; ALU ops complete here in one cycle
//   REQ   | dmem_req held with stable addr/data until gnt
//   WAIT  | load granted, waiting for rvalid
module mem_stage #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  rs2_forward,
  input  logic [RD_W-1:0]  rd,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [1:0]       mem_size,
  input  logic             mem_unsigned,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  mem_stage_if.master      dmem,
  output logic             wb_valid,
  output logic [RD_W-1:0]  wb_rd,
  output logic             wb_reg_write,
  output logic [XLEN-1:0]  wb_data,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [7:0]      wstrb_q, wstrb_d;
  logic            we_q, we_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic [1:0]      size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic [2:0]      off_q, off_d;

  logic            wb_valid_q, wb_valid_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            accept;
  logic            is_mem;
  logic [2:0]      size_mask;
  logic [2:0]      eff_off;
  logic [7:0]      strb_base;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_ext;

`ifdef MEM_MISALIGN_CHK_EN
  logic            misalign_q, misalign_d;
  logic            misaligned;
  assign misaligned = is_mem & (|(alu_result[2:0] & size_mask));
  assign misalign   = misalign_q;
`else
  assign misalign   = 1'b0;
`endif

  assign in_ready       = (state_q == IDLE);
  assign accept         = in_valid & in_ready;
  assign is_mem         = mem_read | mem_write;

  assign dmem.dmem_req   = (state_q == REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;

  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign wb_data        = wb_data_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  always_comb begin
    size_mask = 3'b000;
    strb_base = 8'h01;
    case (mem_size)
      2'd0:    begin size_mask = 3'b000; strb_base = 8'h01; end
      2'd1:    begin size_mask = 3'b001; strb_base = 8'h03; end
      2'd2:    begin size_mask = 3'b011; strb_base = 8'h0F; end
      default: begin size_mask = 3'b111; strb_base = 8'hFF; end
    endcase
  end

  // Lane offset rounded down to the access size; the bus address stays exact.
  assign eff_off  = alu_result[2:0] & ~size_mask;
  assign ld_shift = dmem.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = ld_shift;
    case (size_q)
      2'd0:    ld_ext = {{(XLEN-8){~unsigned_q & ld_shift[7]}},   ld_shift[7:0]};
      2'd1:    ld_ext = {{(XLEN-16){~unsigned_q & ld_shift[15]}}, ld_shift[15:0]};
      2'd2:    ld_ext = {{(XLEN-32){~unsigned_q & ld_shift[31]}}, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    wstrb_d          = wstrb_q;
    we_d             = we_q;
    rd_d             = rd_q;
    reg_write_d      = reg_write_q;
    size_d           = size_q;
    unsigned_d       = unsigned_q;
    off_d            = off_q;
    wb_valid_d       = 1'b0;
    wb_rd_d          = wb_rd_q;
    wb_reg_write_d   = wb_reg_write_q;
    wb_data_d        = wb_data_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
`ifdef MEM_MISALIGN_CHK_EN
    misalign_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          redirect_valid_d = branch_taken;
          if (branch_taken) redirect_pc_d = branch_target;
          if (!is_mem) begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = rd;
            wb_reg_write_d = reg_write;
            wb_data_d      = alu_result;
`ifdef MEM_MISALIGN_CHK_EN
          end else if (misaligned) begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = rd;
            wb_reg_write_d = 1'b0;
            wb_data_d      = alu_result;
            misalign_d     = 1'b1;
`endif
          end else begin
            state_d     = REQ;
            addr_d      = alu_result;
            we_d        = mem_write;
            wdata_d     = mem_write ? (rs2_forward << {eff_off, 3'b000}) : '0;
            wstrb_d     = mem_write ? (strb_base << eff_off) : 8'h00;
            rd_d        = rd;
            reg_write_d = reg_write;
            size_d      = mem_size;
            unsigned_d  = mem_unsigned;
            off_d       = eff_off;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_gnt) begin
          if (we_q) begin
            state_d        = IDLE;
            wb_valid_d     = 1'b1;
            wb_rd_d        = rd_q;
            wb_reg_write_d = 1'b0;
            wb_data_d      = addr_q;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_d        = IDLE;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_reg_write_d = reg_write_q;
          wb_data_d      = ld_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      we_q             <= 1'b0;
      rd_q             <= '0;
      reg_write_q      <= 1'b0;
      size_q           <= '0;
      unsigned_q       <= 1'b0;
      off_q            <= '0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= '0;
      wb_reg_write_q   <= 1'b0;
      wb_data_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
`ifdef MEM_MISALIGN_CHK_EN
      misalign_q       <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      wstrb_q          <= wstrb_d;
      we_q             <= we_d;
      rd_q             <= rd_d;
      reg_write_q      <= reg_write_d;
      size_q           <= size_d;
      unsigned_q       <= unsigned_d;
      off_q            <= off_d;
      wb_valid_q       <= wb_valid_d;
      wb_rd_q          <= wb_rd_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_data_q        <= wb_data_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
`ifdef MEM_MISALIGN_CHK_EN
      misalign_q       <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized instruction/memory timing.
// The bench plays both EX and data memory and predicts every output cycle by cycle.
module tb_mem_stage;
  localparam int XLEN = 64;
  localparam int RD_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [XLEN-1:0]  alu_result, rs2_forward, branch_target;
  logic [RD_W-1:0]  rd;
  logic             reg_write, mem_read, mem_write, mem_unsigned, branch_taken;
  logic [1:0]       mem_size;
  logic             wb_valid, wb_reg_write, redirect_valid, misalign;
  logic [RD_W-1:0]  wb_rd;
  logic [XLEN-1:0]  wb_data, redirect_pc;

  mem_stage_if #(.XLEN(XLEN)) dmem ();

  mem_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2_forward(rs2_forward), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .branch_taken(branch_taken), .branch_target(branch_target),
    .dmem(dmem), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checks_en = 0;

  // Expected outputs after the next rising edge (nxt_*) and after the last one (exp_*).
  bit nxt_ready, nxt_req, nxt_we, nxt_wb, nxt_wb_rw, nxt_wb_chk, nxt_redir, nxt_mis;
  logic [RD_W-1:0] nxt_wb_rd;
  logic [XLEN-1:0] nxt_addr, nxt_wdata, nxt_wb_data, nxt_pc;
  logic [7:0] nxt_wstrb;
  bit exp_ready, exp_req, exp_we, exp_wb, exp_wb_rw, exp_wb_chk, exp_redir, exp_mis;
  logic [RD_W-1:0] exp_wb_rd;
  logic [XLEN-1:0] exp_addr, exp_wdata, exp_wb_data, exp_pc;
  logic [7:0] exp_wstrb;

  int wb_count = 0, redir_count = 0, req_cycles = 0;
  logic [XLEN-1:0] last_wb_data, last_pc, last_wdata;
  logic [7:0] last_wstrb;
  logic last_wb_rw, last_mis;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_ready = nxt_ready;  exp_req = nxt_req;  exp_we = nxt_we;  exp_addr = nxt_addr;
    exp_wdata = nxt_wdata;  exp_wstrb = nxt_wstrb;  exp_wb = nxt_wb;  exp_wb_rd = nxt_wb_rd;
    exp_wb_rw = nxt_wb_rw;  exp_wb_data = nxt_wb_data;  exp_wb_chk = nxt_wb_chk;
    exp_redir = nxt_redir;  exp_pc = nxt_pc;  exp_mis = nxt_mis;
  end

  always @(negedge clk) begin
    if (checks_en) begin
      chk("in_ready", in_ready, exp_ready);
      chk("dmem_req", dmem.dmem_req, exp_req);
      if (exp_req) begin
        chk("dmem_we", dmem.dmem_we, exp_we);
        chk("dmem_addr", dmem.dmem_addr, exp_addr);
        chk("dmem_wstrb", dmem.dmem_wstrb, exp_wstrb);
        if (exp_we) chk("dmem_wdata", dmem.dmem_wdata, exp_wdata);
      end
      chk("wb_valid", wb_valid, exp_wb);
      if (exp_wb) begin
        chk("wb_reg_write", wb_reg_write, exp_wb_rw);
        if (exp_wb_chk) begin
          chk("wb_rd", wb_rd, exp_wb_rd);
          chk("wb_data", wb_data, exp_wb_data);
        end
      end
      chk("redirect_valid", redirect_valid, exp_redir);
      if (exp_redir) chk("redirect_pc", redirect_pc, exp_pc);
      chk("misalign", misalign, exp_mis);
    end
    if (wb_valid) begin wb_count++; last_wb_data = wb_data; last_wb_rw = wb_reg_write; last_mis = misalign; end
    if (redirect_valid) begin redir_count++; last_pc = redirect_pc; end
    if (dmem.dmem_req) begin
      req_cycles++;
      if (dmem.dmem_we) begin last_wstrb = dmem.dmem_wstrb; last_wdata = dmem.dmem_wdata; end
    end
  end

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Load result: pick the addressed bytes, then zero- or sign-extend to 64 bits.
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] d, input int off, input int sz,
                                           input bit uns);
    logic [XLEN-1:0] v, m;
    int bits;
    bits = 8 << sz;
    v = d >> (8 * off);
    if (bits < 64) begin
      m = (64'd1 << bits) - 64'd1;
      v = v & m;
      if (!uns && v[bits-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    nxt_ready = 1; nxt_req = 0; nxt_wb = 0; nxt_wb_chk = 0; nxt_redir = 0; nxt_mis = 0;
    in_valid = 0; reset = 0;
    dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0; dmem.dmem_rdata = rnd64();
  endtask

  // Random EX traffic presented while the stage is busy; it must be ignored.
  task automatic junk();
    in_valid = 1'($urandom_range(0, 1));
    alu_result = rnd64(); rs2_forward = rnd64(); branch_target = rnd64();
    rd = 5'($urandom); reg_write = 1'($urandom); mem_read = 1'($urandom);
    mem_write = 1'($urandom); mem_size = 2'($urandom); mem_unsigned = 1'($urandom);
    branch_taken = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // rst_at: 0 none, 1 reset while requesting, 2 reset while waiting for load data
  task automatic do_instr(input logic [XLEN-1:0] a, input logic [XLEN-1:0] rs2,
                          input logic [RD_W-1:0] rdv, input bit rw, input bit mr, input bit mw,
                          input int sz, input bit uns, input bit bt, input logic [XLEN-1:0] tgt,
                          input int gd, input int rdly, input logic [XLEN-1:0] rdat,
                          input int rst_at);
    int bytes, off, eff;
    bit mem, mis;
    logic [XLEN-1:0] wd;
    logic [7:0] ws;
    bytes = 1 << sz;
    off = int'(a[2:0]);
    eff = off - (off % bytes);
    mem = mr | mw;
`ifdef MEM_MISALIGN_CHK_EN
    mis = mem && (off % bytes != 0);
`else
    mis = 0;
`endif
    in_valid = 1; alu_result = a; rs2_forward = rs2; rd = rdv; reg_write = rw;
    mem_read = mr; mem_write = mw; mem_size = 2'(sz); mem_unsigned = uns;
    branch_taken = bt; branch_target = tgt;
    nxt_redir = bt; nxt_pc = tgt;
    if (!mem) begin
      nxt_wb = 1; nxt_wb_rd = rdv; nxt_wb_rw = rw; nxt_wb_data = a; nxt_wb_chk = 1;
      tick();
      return;
    end
    if (mis) begin
      nxt_wb = 1; nxt_wb_rw = 0; nxt_mis = 1;
      tick();
      return;
    end
    ws = mw ? 8'(((1 << bytes) - 1) << eff) : 8'h00;
    wd = rs2 << (8 * eff);
    nxt_ready = 0; nxt_req = 1; nxt_we = mw; nxt_addr = a; nxt_wstrb = ws; nxt_wdata = wd;
    tick();
    for (int i = 0; i < gd; i++) begin
      junk();
      dmem.dmem_rvalid = 1'($urandom);
      if (rst_at == 1 && i == gd - 1) begin
        reset = 1;
        tick();
        return;
      end
      nxt_ready = 0; nxt_req = 1; nxt_we = mw; nxt_addr = a; nxt_wstrb = ws; nxt_wdata = wd;
      tick();
    end
    junk();
    dmem.dmem_gnt = 1;
    dmem.dmem_rvalid = 1'($urandom);
    if (mw) begin
      nxt_wb = 1; nxt_wb_rw = 0;
      tick();
      return;
    end
    nxt_ready = 0;
    tick();
    if (rst_at == 2) begin
      junk();
      reset = 1;
      tick();
      dmem.dmem_rvalid = 1;
      tick();
      return;
    end
    for (int i = 0; i < rdly; i++) begin
      junk();
      nxt_ready = 0;
      tick();
    end
    junk();
    dmem.dmem_rvalid = 1; dmem.dmem_rdata = rdat;
    nxt_wb = 1; nxt_wb_rd = rdv; nxt_wb_rw = rw; nxt_wb_chk = 1;
    nxt_wb_data = ext(rdat, eff, sz, uns);
    tick();
  endtask

  int wb0, rc0, rq0;

  initial begin
    reset = 1; in_valid = 0; alu_result = '0; rs2_forward = '0; rd = '0; reg_write = 0;
    mem_read = 0; mem_write = 0; mem_size = '0; mem_unsigned = 0; branch_taken = 0;
    branch_target = '0;
    dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0; dmem.dmem_rdata = '0;
    nxt_ready = 1; nxt_req = 0; nxt_wb = 0; nxt_wb_chk = 0; nxt_redir = 0; nxt_mis = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_dmem_req", dmem.dmem_req, 0);
    chk("rst_dmem_addr", dmem.dmem_addr, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    checks_en = 1;
    tick();

    // ALU ops back to back
    wb0 = wb_count;
    for (int i = 0; i < 3; i++)
      do_instr(64'h1234 + 64'(i), '0, 5, 1, 0, 0, 3, 0, 0, '0, 0, 0, '0, 0);
    idle(2);
    chk("alu_wb_count", 64'(wb_count - wb0), 3);
    chk("alu_wb_data", last_wb_data, 64'h1236);

    // store byte with delayed grant
    rq0 = req_cycles;
    do_instr(64'h1003, 64'hAB, 7, 1, 0, 1, 0, 0, 0, '0, 3, 0, '0, 0);
    idle(2);
    chk("sb_wstrb", 64'(last_wstrb), 64'h08);
    chk("sb_wdata_b3", 64'(last_wdata[31:24]), 64'hAB);
    chk("sb_wb_reg_write", 64'(last_wb_rw), 0);
    chk("sb_req_cycles", 64'(req_cycles - rq0), 4);

    // load half, signed then unsigned
    do_instr(64'h2002, '0, 9, 1, 1, 0, 1, 0, 0, '0, 1, 1, 64'h0000_0000_8001_0000, 0);
    idle(2);
    chk("lh_signed", last_wb_data, 64'hFFFF_FFFF_FFFF_8001);
    do_instr(64'h2002, '0, 9, 1, 1, 0, 1, 1, 0, '0, 0, 1, 64'h0000_0000_8001_0000, 0);
    idle(2);
    chk("lh_unsigned", last_wb_data, 64'h8001);

    // taken branch on ALU op
    rc0 = redir_count;
    do_instr(64'h55, '0, 3, 1, 0, 0, 3, 0, 1, 64'h400, 0, 0, '0, 0);
    idle(2);
    chk("br_redirect_pc", last_pc, 64'h400);
    chk("br_redirect_count", 64'(redir_count - rc0), 1);

    // reset while waiting for load data, then a late rvalid
    wb0 = wb_count;
    do_instr(64'h2000, '0, 4, 1, 1, 0, 3, 0, 0, '0, 1, 0, '0, 2);
    idle(2);
    chk("rst_wait_no_wb", 64'(wb_count - wb0), 0);
    chk("rst_wait_in_ready", in_ready, 1);

    // word load at 0x3002
    rq0 = req_cycles;
    do_instr(64'h3002, '0, 6, 1, 1, 0, 2, 0, 0, '0, 0, 0, 64'h1122_3344_5566_7788, 0);
    idle(2);
`ifdef MEM_MISALIGN_CHK_EN
    chk("mis_no_req", 64'(req_cycles - rq0), 0);
    chk("mis_flag", 64'(last_mis), 1);
    chk("mis_wb_reg_write", 64'(last_wb_rw), 0);
`else
    chk("lw_req_cycles", 64'(req_cycles - rq0), 1);
    chk("lw_round_data", last_wb_data, 64'h5566_7788);
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int kind, rst_at;
      bit mr, mw;
      kind = $urandom_range(0, 9);
      mr = (kind >= 4 && kind <= 6) || kind == 9;
      mw = (kind >= 7);
      rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0;
      if (rst_at == 1 && !mr && !mw) rst_at = 0;
      do_instr(rnd64(), rnd64(), 5'($urandom), 1'($urandom), mr, mw, $urandom_range(0, 3),
               1'($urandom), ($urandom_range(0, 3) == 0), rnd64(),
               (rst_at == 1) ? $urandom_range(1, 3) : $urandom_range(0, 3),
               $urandom_range(0, 3), rnd64(), rst_at);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
